// File: rtl/seq_bit_serializer.sv
// Parallel-in, serial-out front end for the 10110 sequence detector: valid/ready word input, one bit per clock out.
// Define SER_PARITY_EN to append an even-parity cycle after each word's payload bits.
module seq_bit_serializer #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_done
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT
`ifdef SER_PARITY_EN
      ,
      PARITY
`endif
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] shreg;
   logic             accept;
`ifdef SER_PARITY_EN
   logic             parity;
`endif

   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] tail_word(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   // Ready on the final cycle of a frame lets the next word follow with no bubble.
   always_comb begin
      din_ready = 1'b0;
      if (rst) begin
`ifdef SER_PARITY_EN
         din_ready = (state == IDLE) || (state == PARITY);
`else
         din_ready = (state == IDLE) || ((state == SHIFT) && (count == LAST));
`endif
      end
   end

   assign accept = din_valid && din_ready;

   // The first bit is registered at the accept edge, so count always names the bit currently on ser_out.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         count      <= '0;
         shreg      <= '0;
         ser_out    <= 1'b0;
         ser_valid  <= 1'b0;
         frame_done <= 1'b0;
`ifdef SER_PARITY_EN
         parity     <= 1'b0;
`endif
      end else if (accept) begin
         state      <= SHIFT;
         count      <= '0;
         shreg      <= tail_word(din);
         ser_out    <= head_bit(din);
         ser_valid  <= 1'b1;
         frame_done <= 1'b0;
`ifdef SER_PARITY_EN
         parity     <= ^din;
`endif
      end else begin
         case (state)
            SHIFT: begin
               if (count != LAST) begin
                  count      <= count + CW'(1);
                  shreg      <= tail_word(shreg);
                  ser_out    <= head_bit(shreg);
                  ser_valid  <= 1'b1;
`ifdef SER_PARITY_EN
                  frame_done <= 1'b0;
`else
                  frame_done <= ((count + CW'(1)) == LAST);
`endif
               end else begin
`ifdef SER_PARITY_EN
                  state      <= PARITY;
                  count      <= '0;
                  ser_out    <= parity;
                  ser_valid  <= 1'b1;
                  frame_done <= 1'b1;
`else
                  state      <= IDLE;
                  count      <= '0;
                  shreg      <= '0;
                  ser_out    <= 1'b0;
                  ser_valid  <= 1'b0;
                  frame_done <= 1'b0;
`endif
               end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
               state      <= IDLE;
               count      <= '0;
               shreg      <= '0;
               ser_out    <= 1'b0;
               ser_valid  <= 1'b0;
               frame_done <= 1'b0;
            end
`endif
            default: begin
               state      <= IDLE;
               count      <= '0;
               ser_out    <= 1'b0;
               ser_valid  <= 1'b0;
               frame_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: MSB-first and LSB-first instances share stimulus and are checked
// against a bit-stream scoreboard fed by a frame-countdown model of the handshake.
module tb_seq_bit_serializer;

   localparam int W = 8;
`ifdef SER_PARITY_EN
   localparam int FRAME = W + 1;
`else
   localparam int FRAME = W;
`endif

   logic         clk;
   logic         rst;
   logic [W-1:0] din;
   logic         din_valid;
   logic         rdy_m, so_m, sv_m, fd_m;
   logic         rdy_l, so_l, sv_l, fd_l;

   seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(rdy_m), .ser_out(so_m), .ser_valid(sv_m), .frame_done(fd_m)
   );

   seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(rdy_l), .ser_out(so_l), .ser_valid(sv_l), .frame_done(fd_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] word;
      logic [W-1:0] exp_msb;
      logic [W-1:0] exp_lsb;
      logic         exp_par;
   } vec_t;

   vec_t vecs[8];

   int tests_run    = 0;
   int tests_failed = 0;

   int           m_left = 0;
   logic         acc    = 1'b0;
   logic [W-1:0] pend_m, pend_l;
   logic         pend_p;
   logic         qm[$];
   logic         ql[$];

   task automatic compare(input string name, input logic act, input logic exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      logic exp_valid, exp_fd, exp_rdy, bm, bl;
      exp_valid = (m_left > 0);
      exp_fd    = (m_left == 1);
      exp_rdy   = rst && (m_left <= 1);
      compare("msb_ser_valid", sv_m, exp_valid);
      compare("lsb_ser_valid", sv_l, exp_valid);
      compare("msb_frame_done", fd_m, exp_fd);
      compare("lsb_frame_done", fd_l, exp_fd);
      compare("msb_din_ready", rdy_m, exp_rdy);
      compare("lsb_din_ready", rdy_l, exp_rdy);
      bm = 1'b0;
      bl = 1'b0;
      if (exp_valid) begin
         if (qm.size() == 0 || ql.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL scoreboard_empty: queue sizes %0d/%0d, expected nonzero at %0t",
                     qm.size(), ql.size(), $time);
         end else begin
            bm = qm.pop_front();
            bl = ql.pop_front();
         end
      end
      compare("msb_ser_out", so_m, bm);
      compare("lsb_ser_out", so_l, bl);
   endtask

   // One clock: advance the model with the inputs seen at the edge, then check just after it.
   task automatic tick();
      @(posedge clk);
      acc = 1'b0;
      if (!rst) begin
         m_left = 0;
         qm.delete();
         ql.delete();
      end else begin
         acc = din_valid && (m_left <= 1);
         if (m_left > 0) m_left--;
         if (acc) begin
            for (int i = W - 1; i >= 0; i--) begin
               qm.push_back(pend_m[i]);
               ql.push_back(pend_l[i]);
            end
`ifdef SER_PARITY_EN
            qm.push_back(pend_p);
            ql.push_back(pend_p);
`endif
            m_left = FRAME;
         end
      end
      #1;
      checkOutput();
   endtask

   task automatic applyStimulus(input logic v, input logic [W-1:0] d,
                                input logic [W-1:0] em, input logic [W-1:0] el, input logic ep);
      din_valid = v;
      din       = d;
      pend_m    = em;
      pend_l    = el;
      pend_p    = ep;
   endtask

   task automatic applyWord(input logic v, input logic [W-1:0] d);
      logic [W-1:0] rev;
      for (int i = 0; i < W; i++) rev[W-1-i] = d[i];
      applyStimulus(v, d, d, rev, ^d);
   endtask

   task automatic waitAccept();
      for (int k = 0; k < 4 * FRAME; k++) begin
         tick();
         if (acc) break;
      end
   endtask

   task automatic idleTicks(input int n);
      din_valid = 1'b0;
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      vecs[0] = '{8'b10110110, 8'b10110110, 8'b01101101, 1'b1};
      vecs[1] = '{8'b00001101, 8'b00001101, 8'b10110000, 1'b1};
      vecs[2] = '{8'hB6,       8'hB6,       8'b01101101, 1'b1};
      vecs[3] = '{8'h2D,       8'h2D,       8'b10110100, 1'b0};
      vecs[4] = '{8'hFF,       8'hFF,       8'hFF,       1'b0};
      vecs[5] = '{8'h00,       8'h00,       8'h00,       1'b0};
      vecs[6] = '{8'h01,       8'h01,       8'b10000000, 1'b1};
      vecs[7] = '{8'h80,       8'h80,       8'b00000001, 1'b1};

      rst = 1'b0;
      applyWord(1'b1, 8'hA5);
      tick();
      tick();
      rst = 1'b1;
      din_valid = 1'b0;
      tick();

      // Isolated words from the table, each followed by an idle gap.
      for (int n = 0; n < 8; n++) begin
         applyStimulus(1'b1, vecs[n].word, vecs[n].exp_msb, vecs[n].exp_lsb, vecs[n].exp_par);
         tick();
         idleTicks(FRAME + 1);
      end

      // Back-to-back B6 then 2D with valid held high throughout.
      applyStimulus(1'b1, vecs[2].word, vecs[2].exp_msb, vecs[2].exp_lsb, vecs[2].exp_par);
      waitAccept();
      applyStimulus(1'b1, vecs[3].word, vecs[3].exp_msb, vecs[3].exp_lsb, vecs[3].exp_par);
      waitAccept();
      idleTicks(FRAME + 1);

      // Stall: FF offered mid-word waits for the frame's last cycle.
      applyWord(1'b1, 8'h5A);
      tick();
      idleTicks(3);
      applyWord(1'b1, 8'hFF);
      waitAccept();
      idleTicks(FRAME + 1);

      // Reset in the middle of a word, then a clean restart.
      applyWord(1'b1, 8'hC3);
      tick();
      idleTicks(4);
      rst = 1'b0;
      applyWord(1'b1, 8'h3C);
      tick();
      rst = 1'b1;
      din_valid = 1'b0;
      tick();
      applyWord(1'b1, 8'h96);
      tick();
      idleTicks(FRAME + 1);

      // Random words with random valid gaps.
      for (int n = 0; n < 20; n++) begin
         applyWord(1'b1, W'($urandom));
         waitAccept();
         if ($urandom_range(0, 1) == 0) idleTicks($urandom_range(0, 3));
      end
      idleTicks(FRAME + 2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Parallel-in, serial-out stage that sits directly upstream of the overlapping 10110 Moore sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on ser_out.
- ser_out is intended to drive the detector's in_seq input.
- Supports back-to-back words with no idle bubble, so bit patterns spanning word boundaries reach the detector unbroken.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = din[WIDTH-1] is sent first; 0 = din[0] is sent first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- din  input  WIDTH  parallel word; sampled only on an accept.
- din_valid  input  1  upstream has a word on din.
- din_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit; registered.
- ser_valid  output  1  ser_out carries a payload bit this cycle; registered.
- frame_done  output  1  one-cycle pulse coincident with the last bit of a word; registered.

Behaviour:
- Reset:
  - rst is sampled only on the rising edge of clk (synchronous, active-low).
  - While rst=0 at an edge: state=IDLE, bit counter=0, shift register=0, ser_out=0, ser_valid=0, frame_done=0.
  - din_ready is forced to 0 whenever rst=0.
- Accept rule: a word is accepted at a rising edge where rst=1, din_valid=1 and din_ready=1.
- din_ready (combinational from state/counter):
  - Equals 1 when rst=1 and either state=IDLE, or state=SHIFT with the counter on the last bit (count=WIDTH-1).
  - Equals 0 otherwise.
- States:
  - IDLE: ser_out=0, ser_valid=0. On accept: load the shift register from din, go to SHIFT, count=0.
  - SHIFT: each cycle presents one bit with ser_valid=1, and the counter increments.
  - At count=WIDTH-1, frame_done=1 with the last bit. At that edge:
    - Accept pending: reload and stay in SHIFT with count=0, so the first bit of the new word follows the last bit of the old one in the next cycle.
    - No accept: return to IDLE.
- Latency: first bit appears on ser_out in the cycle immediately after the accept edge. One word occupies exactly WIDTH consecutive ser_valid cycles.
- Bit order:
  - MSB_FIRST=1: din[WIDTH-1] down to din[0].
  - MSB_FIRST=0: din[0] up to din[WIDTH-1].
- Idle value: ser_out is held at 0 while not shifting. The detector therefore sees zeros and cannot complete 10110 from stale data.
- Stall: din_valid=1 while din_ready=0 causes no accept. din must be held by upstream (standard valid/ready). The current word is never corrupted.
- Reset mid-word: the partial word is discarded, outputs return to reset values at that edge, and no frame_done is issued.
- Counter: ceil(log2(WIDTH)) bits. It never exceeds WIDTH-1 and wraps only via reload or return to IDLE.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - After the last payload bit, one extra cycle (state PARITY) outputs the even-parity bit (XOR of the word) with ser_valid=1.
  - frame_done moves to the parity cycle.
  - din_ready is high in the parity cycle instead of on the last payload bit.
  - Each word occupies WIDTH+1 cycles.
- Undefined: no PARITY state, behaviour exactly as above.

Test Plan:
- Reset then single word: rst=0 for 2 edges, then 1; din=8'b10110110, one-cycle valid -> ser_out=1,0,1,1,0,1,1,0 on 8 consecutive cycles, ser_valid=1 for those 8, frame_done on the 8th only, then ser_out=0 and din_ready=1.
- Back-to-back: din_valid held high with 8'hB6 then 8'h2D -> 16 contiguous ser_valid cycles with no gap; frame_done at bits 8 and 16; din_ready high only in IDLE and on bits 8/16.
- Stall: assert din_valid=1 with din=8'hFF at bit 3 of a word -> not accepted until the last-bit cycle; the first word's bits are unaltered.
- Reset mid-word: assert rst=0 after bit 4 -> the next cycle has ser_out=0, ser_valid=0, frame_done=0, din_ready=0; after release din_ready=1, and the new word shifts cleanly.
- MSB_FIRST=0 with din=8'b00001101 -> ser_out=1,0,1,1,0,0,0,0.
- SER_PARITY_EN with din=8'b10110110 (five 1s) -> 8 payload bits, then parity bit 1 in cycle 9 with frame_done; din_ready asserted in cycle 9 only.
